// File: rtl/clk_converter.sv
// clk_converter: divides CLK into clk_out with a (size+1)-cycle half period.
// size is re-sampled every cycle; the >= compare lets a lowered size end the phase at once.
module clk_converter #(
    parameter int WIDTH = 27
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] size,
    output logic             clk_out
);
    logic [WIDTH-1:0] cnt_q = '0;
    logic [WIDTH-1:0] cnt_d;
    logic             clk_out_q = 1'b0;
    logic             clk_out_d;
    logic             wrap;
    always_comb begin
        wrap      = cnt_q >= size;
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        clk_out_d = wrap ? ~clk_out_q : clk_out_q;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
        end
    end
    assign clk_out = clk_out_q;
endmodule

// File: tb/tb_clk_converter.sv
// tb_clk_converter: directed vectors push the expected clk_out after each edge into a
// scoreboard queue; per-DUT monitors pop and compare on the falling edge.
module tb_clk_converter;
    typedef struct {
        logic  e;
        string t;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [26:0] size = 27'd419;
    logic        clk_out;
    logic        rst4 = 1'b1;
    logic [3:0]  size4 = 4'd15;
    logic        clk_out4;
    exp_t        qa[$];
    exp_t        q4[$];
    int          tests = 0;
    int          fails = 0;

    clk_converter dut (.CLK(CLK), .RESET(RESET), .size(size), .clk_out(clk_out));
    clk_converter #(.WIDTH(4)) dut4 (.CLK(CLK), .RESET(rst4), .size(size4), .clk_out(clk_out4));

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (qa.size() > 0) begin
            exp_t x;
            x = qa.pop_front();
            tests++;
            if (clk_out !== x.e) begin
                fails++;
                $display("FAIL %s t=%0t: clk_out=%b expected %b", x.t, $time, clk_out, x.e);
            end
        end
    end

    always @(negedge CLK) begin
        if (q4.size() > 0) begin
            exp_t x;
            x = q4.pop_front();
            tests++;
            if (clk_out4 !== x.e) begin
                fails++;
                $display("FAIL %s t=%0t: clk_out4=%b expected %b", x.t, $time, clk_out4, x.e);
            end
        end
    end

    task automatic cyc(input logic r, input logic [26:0] s, input logic e, input string t);
        RESET = r;
        size  = s;
        @(posedge CLK);
        qa.push_back('{e, t});
        #1;
    endtask

    task automatic cyc4(input logic r, input logic [3:0] s, input logic e, input string t);
        rst4  = r;
        size4 = s;
        @(posedge CLK);
        q4.push_back('{e, t});
        #1;
    endtask

    task automatic run(input int n, input logic [26:0] s, input logic e, input string t);
        repeat (n) cyc(1'b0, s, e, t);
    endtask

    task automatic run4(input int n, input logic [3:0] s, input logic e, input string t);
        repeat (n) cyc4(1'b0, s, e, t);
    endtask

    initial begin
        #1;
        tests++;
        if (clk_out !== 1'b0 || clk_out4 !== 1'b0) begin
            fails++;
            $display("FAIL powerup: clk_out=%b clk_out4=%b expected 0 0", clk_out, clk_out4);
        end
        // size=419: 420 low (incl. reset edge), 420 high, 420 low, then high
        cyc(1'b1, 27'd419, 1'b0, "reset");
        cyc(1'b1, 27'd419, 1'b0, "reset");
        run(419, 27'd419, 1'b0, "s419_low1");
        run(420, 27'd419, 1'b1, "s419_high1");
        run(420, 27'd419, 1'b0, "s419_low2");
        run(1, 27'd419, 1'b1, "s419_rise2");
        // size=0: toggles every edge
        cyc(1'b1, 27'd0, 1'b0, "s0_reset");
        cyc(1'b0, 27'd0, 1'b1, "s0_t1");
        cyc(1'b0, 27'd0, 1'b0, "s0_t2");
        cyc(1'b0, 27'd0, 1'b1, "s0_t3");
        cyc(1'b0, 27'd0, 1'b0, "s0_t4");
        // size=3 pattern, then size lowered to 1 at cnt=3
        cyc(1'b1, 27'd3, 1'b0, "s3_reset");
        run(3, 27'd3, 1'b0, "s3_low1");
        run(4, 27'd3, 1'b1, "s3_high");
        run(4, 27'd3, 1'b0, "s3_low2");
        cyc(1'b0, 27'd1, 1'b1, "s3to1_toggle");
        cyc(1'b0, 27'd1, 1'b1, "s1_a");
        cyc(1'b0, 27'd1, 1'b0, "s1_b");
        cyc(1'b0, 27'd1, 1'b0, "s1_c");
        cyc(1'b0, 27'd1, 1'b1, "s1_d");
        cyc(1'b0, 27'd1, 1'b1, "s1_e");
        cyc(1'b0, 27'd1, 1'b0, "s1_f");
        // size=5: reset mid high phase at cnt=2
        cyc(1'b1, 27'd5, 1'b0, "s5_reset");
        run(5, 27'd5, 1'b0, "s5_low");
        run(3, 27'd5, 1'b1, "s5_high");
        cyc(1'b1, 27'd5, 1'b0, "s5_midreset");
        run(5, 27'd5, 1'b0, "s5_relow");
        run(1, 27'd5, 1'b1, "s5_rerise");
        // size=2 raised to 6 at cnt=1
        cyc(1'b1, 27'd2, 1'b0, "s2_reset");
        cyc(1'b0, 27'd2, 1'b0, "s2_cnt1");
        run(5, 27'd6, 1'b0, "s2to6_low");
        run(7, 27'd6, 1'b1, "s6_high");
        run(7, 27'd6, 1'b0, "s6_low");
        run(1, 27'd6, 1'b1, "s6_rise");
        // WIDTH=4, size=15: 16-cycle half period with all-ones wrap
        cyc4(1'b1, 4'd15, 1'b0, "w4_reset");
        run4(15, 4'd15, 1'b0, "w4_low1");
        run4(16, 4'd15, 1'b1, "w4_high");
        run4(16, 4'd15, 1'b0, "w4_low2");
        run4(1, 4'd15, 1'b1, "w4_rise");
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if (qa.size() != 0 || q4.size() != 0) begin
            fails++;
            $display("FAIL drain: qa=%0d q4=%0d expected 0 0", qa.size(), q4.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
